// File: rtl/cfglut_pkg.sv
// Shared types and constants for the CFGLUT5 reconfiguration controller.
package cfglut_pkg;

  localparam int INIT_W   = 32;
  localparam int MAX_LUTS = 16;
  localparam int CNT_W    = $clog2(INIT_W);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_SETTLE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/cfglut_shifter.sv
// Parallel-in serial-out INIT register with bit counter; shifts MSB first.
module cfglut_shifter
  import cfglut_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [INIT_W-1:0] data_i,
  output logic              sdo_o,
  output logic              last_o
);

  logic [INIT_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      shreg_d = data_i;
      cnt_d   = '0;
    end else if (shift_i) begin
      shreg_d = {shreg_q[INIT_W-2:0], 1'b0};
      cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sdo_o  = shreg_q[INIT_W-1];
  assign last_o = (cnt_q == CNT_W'(INIT_W - 1));

endmodule

// File: rtl/cfglut_reconfig_ctrl.sv
// Sequences serial INIT reloads into one of NUM_LUTS CFGLUT5 sites:
// handshake, target decode and IDLE/SHIFT/SETTLE/DONE control.
module cfglut_reconfig_ctrl #(
  parameter int NUM_LUTS = 4,
  parameter int INIT_W   = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [3:0]          req_lut,
  input  logic [INIT_W-1:0]   req_init,
  output logic                cdi,
  output logic [NUM_LUTS-1:0] ce,
  output logic                busy,
  output logic                done,
  output logic                err
);
  import cfglut_pkg::*;

  localparam int LUT_LIMIT = (NUM_LUTS < MAX_LUTS) ? NUM_LUTS : MAX_LUTS;

  state_e     state_q, state_d;
  logic [3:0] lut_q, lut_d;
  logic       err_q, err_d;
  logic       load, shift, last, sdo;
  logic       accept, lut_ok;

  assign req_ready = rst_n && (state_q == ST_IDLE);
  assign accept    = req_valid && req_ready;
  assign lut_ok    = ({1'b0, req_lut} < 5'(LUT_LIMIT));

  always_comb begin
    state_d = state_q;
    lut_d   = lut_q;
    err_d   = 1'b0;
    load    = 1'b0;
    shift   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (lut_ok) begin
            load    = 1'b1;
            lut_d   = req_lut;
            state_d = ST_SHIFT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        shift = 1'b1;
        if (last) state_d = ST_SETTLE;
      end
      ST_SETTLE: state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      lut_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lut_q   <= lut_d;
      err_q   <= err_d;
    end
  end

  cfglut_shifter u_shifter (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (load),
    .shift_i (shift),
    .data_i  (req_init),
    .sdo_o   (sdo),
    .last_o  (last)
  );

  // cdi is qualified by SHIFT so it idles low whenever no ce is active.
  generate
    for (genvar gi = 0; gi < NUM_LUTS; gi++) begin : g_ce
      assign ce[gi] = (state_q == ST_SHIFT) && (lut_q == 4'(gi));
    end
  endgenerate

  assign cdi  = (state_q == ST_SHIFT) && sdo;
  assign busy = (state_q == ST_SHIFT) || (state_q == ST_SETTLE);
  assign done = (state_q == ST_DONE);
  assign err  = err_q;

endmodule

// File: tb/tb_cfglut_reconfig_ctrl.sv
// Randomized self-checking bench for cfglut_reconfig_ctrl with behavioural
// CFGLUT5 models on every ce line and an expected-INIT scoreboard.
module tb_cfglut_reconfig_ctrl;

  localparam int NUM_LUTS = 4;
  localparam int INIT_W   = 32;
  localparam int VW       = NUM_LUTS + 5;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                req_valid = 1'b0;
  logic [3:0]          req_lut = '0;
  logic [INIT_W-1:0]   req_init = '0;
  logic                req_ready, cdi, busy, done, err;
  logic [NUM_LUTS-1:0] ce;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [31:0] lut_model [NUM_LUTS];
  logic [31:0] exp_lut   [NUM_LUTS];
  bit          exp_known [NUM_LUTS];

  cfglut_reconfig_ctrl #(.NUM_LUTS(NUM_LUTS), .INIT_W(INIT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_lut   (req_lut),
    .req_init  (req_init),
    .cdi       (cdi),
    .ce        (ce),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // CFGLUT5 behaviour: shift cdi in at the LSB on every enabled edge.
  always @(posedge clk) begin
    for (int i = 0; i < NUM_LUTS; i++)
      if (ce[i]) lut_model[i] <= {lut_model[i][30:0], cdi};
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [VW-1:0] observed();
    return {ce, cdi, busy, done, err, req_ready};
  endfunction

  task automatic check_idle(input string tag);
    logic [VW-1:0] got;
    got = observed();
    n_vec++;
    if (got !== VW'(1)) begin
      n_err++;
      $display("FAIL %s got %b expected %b", tag, got, VW'(1));
    end
  endtask

  task automatic check_models(input string tag);
    for (int i = 0; i < NUM_LUTS; i++) begin
      if (exp_known[i]) begin
        n_vec++;
        if (lut_model[i] !== exp_lut[i]) begin
          n_err++;
          $display("FAIL %s lut%0d_init got %h expected %h", tag, i, lut_model[i], exp_lut[i]);
        end
      end
    end
  endtask

  // One full reload from an idle cycle; returns in the idle cycle after done.
  task automatic do_reload(input logic [3:0] lut, input logic [31:0] init,
                           input bit toggle, input bit hold,
                           input logic [3:0] nlut, input logic [31:0] ninit,
                           output int start_cyc);
    int n;
    logic [NUM_LUTS-1:0] ece;
    logic [VW-1:0] got, expv;
    req_valid = 1'b1;
    req_lut   = lut;
    req_init  = init;
    n = 0;
    do begin
      next_cycle();
      n++;
    end while (ce == '0 && n < 40);
    n_vec++;
    if (n != 1) begin
      n_err++;
      $display("FAIL accept_latency lut=%0d got %0d cycles expected 1", lut, n);
    end
    start_cyc = cyc;
    if (hold) begin
      req_lut  = nlut;
      req_init = ninit;
    end else begin
      req_valid = 1'b0;
    end
    ece = '0;
    ece[lut] = 1'b1;
    for (int k = 0; k < 32; k++) begin
      if (k > 0) next_cycle();
      got  = observed();
      expv = {ece, init[31-k], 1'b1, 1'b0, 1'b0, 1'b0};
      n_vec++;
      if (got !== expv) begin
        n_err++;
        $display("FAIL shift lut=%0d k=%0d got %b expected %b", lut, k, got, expv);
      end
      if (toggle) begin
        req_init = $urandom;
        req_lut  = 4'($urandom_range(0, 15));
      end
    end
    next_cycle();
    got  = observed();
    expv = {{NUM_LUTS{1'b0}}, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    n_vec++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL settle lut=%0d got %b expected %b", lut, got, expv);
    end
    next_cycle();
    got  = observed();
    expv = {{NUM_LUTS{1'b0}}, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    n_vec++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL done_cycle lut=%0d cycles=%0d got %b expected %b", lut, cyc - start_cyc + 1, got, expv);
    end
    exp_lut[lut]   = init;
    exp_known[lut] = 1'b1;
    check_models("after_done");
    next_cycle();
    check_idle("post_done_idle");
    $display("reload lut=%0d init=%h toggle=%0d start_cyc=%0d", lut, init, toggle, start_cyc);
  endtask

  task automatic bad_request(input logic [3:0] lut);
    logic [VW-1:0] got, expv;
    req_valid = 1'b1;
    req_lut   = lut;
    req_init  = $urandom;
    next_cycle();
    got  = observed();
    expv = {{NUM_LUTS{1'b0}}, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    n_vec++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL bad_lut_err lut=%0d got %b expected %b", lut, got, expv);
    end
    req_valid = 1'b0;
    next_cycle();
    check_idle("bad_lut_after");
    $display("reject lut=%0d", lut);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) next_cycle();
    n_vec++;
    if (observed() !== VW'(0)) begin
      n_err++;
      $display("FAIL reset_state got %b expected %b", observed(), VW'(0));
    end
    rst_n = 1'b1;
    #1;
    check_idle("ready_after_reset");
    next_cycle();
    check_idle("idle_after_reset");
    $display("reset released");
  endtask

  task automatic test_directed();
    int s;
    do_reload(4'd2, 32'hF0F00000, 1'b0, 1'b0, 4'd0, 32'd0, s);
  endtask

  task automatic test_bad_lut();
    bad_request(4'd5);
    bad_request(4'd15);
  endtask

  task automatic test_back_to_back();
    int s0, s1;
    do_reload(4'd0, 32'hAAAAAAAA, 1'b0, 1'b1, 4'd1, 32'h00000001, s0);
    do_reload(4'd1, 32'h00000001, 1'b0, 1'b0, 4'd0, 32'd0, s1);
    n_vec++;
    if (s1 - s0 != 35) begin
      n_err++;
      $display("FAIL back_to_back_spacing got %0d expected 35", s1 - s0);
    end
  endtask

  task automatic test_toggle();
    int s;
    do_reload(4'd3, $urandom, 1'b1, 1'b0, 4'd0, 32'd0, s);
  endtask

  task automatic test_reset_mid_shift();
    int n;
    bit saw_done;
    req_valid = 1'b1;
    req_lut   = 4'd1;
    req_init  = $urandom;
    n = 0;
    do begin
      next_cycle();
      n++;
    end while (ce == '0 && n < 40);
    req_valid = 1'b0;
    n_vec++;
    if (n != 1) begin
      n_err++;
      $display("FAIL midreset_accept got %0d cycles expected 1", n);
    end
    repeat (10) next_cycle();
    rst_n = 1'b0;
    next_cycle();
    n_vec++;
    if (observed() !== VW'(0)) begin
      n_err++;
      $display("FAIL midreset_drop got %b expected %b", observed(), VW'(0));
    end
    rst_n = 1'b1;
    exp_known[1] = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      next_cycle();
      if (done) saw_done = 1'b1;
    end
    n_vec++;
    if (saw_done) begin
      n_err++;
      $display("FAIL midreset_no_done got done=1 expected no done pulse");
    end
    $display("reset mid-shift abandoned lut=1");
    test_toggle_free(4'd1);
  endtask

  task automatic test_toggle_free(input logic [3:0] lut);
    int s;
    do_reload(lut, $urandom, 1'b0, 1'b0, 4'd0, 32'd0, s);
  endtask

  task automatic test_random();
    int s;
    for (int it = 0; it < 24; it++) begin
      repeat ($urandom_range(0, 3)) begin
        next_cycle();
        check_idle("random_gap");
      end
      if ($urandom_range(0, 5) == 0)
        bad_request(4'($urandom_range(NUM_LUTS, 15)));
      else
        do_reload(4'($urandom_range(0, NUM_LUTS - 1)), $urandom,
                  1'($urandom_range(0, 1)), 1'b0, 4'd0, 32'd0, s);
    end
  endtask

  initial begin
    for (int i = 0; i < NUM_LUTS; i++) begin
      exp_known[i] = 1'b0;
      exp_lut[i]   = '0;
    end
    test_reset();
    test_directed();
    test_bad_lut();
    test_back_to_back();
    test_toggle();
    test_reset_mid_shift();
    test_random();
    check_models("final");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
